// File: rtl/md_unit.sv
// ============================================================================
// Module   : md_unit
// Purpose  : Multi-cycle multiply/divide unit that owns the HI/LO registers.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        wr_hl,
    input  logic        flush,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

    state_t      r_state, w_state_n;
    logic [3:0]  r_cnt,   w_cnt_n;
    logic [31:0] r_a,     w_a_n;
    logic [31:0] r_b,     w_b_n;
    logic [1:0]  r_op,    w_op_n;
    logic [31:0] r_hi,    w_hi_n;
    logic [31:0] r_lo,    w_lo_n;

    logic [63:0] w_prod_s, w_prod_u;
    logic [31:0] w_abs_a, w_abs_b, w_dvd, w_dvs, w_q, w_r;
    logic [31:0] w_div_hi, w_div_lo;
    logic        w_dvs_zero;

    // Results are formed from the latched operands only, so HI/LO never see A/B directly.
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed divide works on magnitudes; 0x8000_0000 magnitude is exactly 2^31 unsigned.
    assign w_abs_a    = r_a[31] ? (~r_a + 32'd1) : r_a;
    assign w_abs_b    = r_b[31] ? (~r_b + 32'd1) : r_b;
    assign w_dvd      = r_op[0] ? r_a : w_abs_a;
    assign w_dvs      = r_op[0] ? r_b : w_abs_b;
    assign w_dvs_zero = (w_dvs == 32'd0);
    assign w_q        = w_dvs_zero ? 32'd0 : (w_dvd / w_dvs);
    assign w_r        = w_dvs_zero ? 32'd0 : (w_dvd % w_dvs);

    always_comb begin
        w_div_lo = w_q;
        w_div_hi = w_r;
        if (!r_op[0]) begin
            if (r_a[31] ^ r_b[31]) begin
                w_div_lo = ~w_q + 32'd1;
            end
            if (r_a[31]) begin
                w_div_hi = ~w_r + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_a_n     = r_a;
        w_b_n     = r_b;
        w_op_n    = r_op;
        w_hi_n    = r_hi;
        w_lo_n    = r_lo;
        case (r_state)
            IDLE: begin
                // start takes priority; a coincident wr_hl is dropped.
                if (start) begin
                    if (!flush && !op[2]) begin
                        w_a_n     = A;
                        w_b_n     = B;
                        w_op_n    = op[1:0];
                        w_cnt_n   = op[1] ? c_div_cnt : c_mult_cnt;
                        w_state_n = RUN;
                    end
                end else if (wr_hl && !flush) begin
                    if (op == 3'd4) begin
                        w_hi_n = A;
                    end else if (op == 3'd5) begin
                        w_lo_n = A;
                    end
                end
            end
            RUN: begin
                w_cnt_n = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_n = IDLE;
                    case (r_op)
                        2'd0: {w_hi_n, w_lo_n} = w_prod_s;
                        2'd1: {w_hi_n, w_lo_n} = w_prod_u;
                        default: begin
                            if (!w_dvs_zero) begin
                                w_hi_n = w_div_hi;
                                w_lo_n = w_div_lo;
                            end
                        end
                    endcase
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 2'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_a     <= w_a_n;
            r_b     <= w_b_n;
            r_op    <= w_op_n;
            r_hi    <= w_hi_n;
            r_lo    <= w_lo_n;
        end
    end

    assign busy = (r_state == RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module   : tb_md_unit
// Purpose  : Directed and randomized self-checking bench for md_unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, wr_hl, flush;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    // Reference model: cycles left until commit plus the pending result.
    int          m_rem;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_commit;
    bit          cmp_en = 1'b0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .wr_hl (wr_hl),
        .flush (flush),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rem = 0; m_hi = 32'd0; m_lo = 32'd0;
        p_hi = 32'd0; p_lo = 32'd0; p_commit = 1'b0;
    endtask

    task automatic model_issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = a;
        ub = b;
        p_commit = 1'b1;
        case (o)
            3'd0: begin sp = sa * sb; p_hi = sp[63:32]; p_lo = sp[31:0]; end
            3'd1: begin up = ua * ub; p_hi = up[63:32]; p_lo = up[31:0]; end
            3'd2: begin
                if (b == 32'd0) p_commit = 1'b0;
                else begin sq = sa / sb; sr = sa % sb; p_lo = sq[31:0]; p_hi = sr[31:0]; end
            end
            default: begin
                if (b == 32'd0) p_commit = 1'b0;
                else begin p_lo = a / b; p_hi = a % b; end
            end
        endcase
        m_rem = (o < 3'd2) ? 5 : 10;
    endtask

    task automatic model_step(input bit s, input bit w, input bit f, input logic [2:0] o,
                              input logic [31:0] a, input logic [31:0] b);
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && p_commit) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (s) begin
            if (!f && o < 3'd4) model_issue(o, a, b);
        end else if (w && !f) begin
            if (o == 3'd4) m_hi = a;
            else if (o == 3'd5) m_lo = a;
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
        end
    end

    task automatic cyc(input bit s, input bit w, input bit f, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b);
        start = s; wr_hl = w; flush = f; op = o; A = a; B = b;
        @(posedge clk);
        if (reset) model_step(s, w, f, o, a, b);
        #1;
        start = 1'b0; wr_hl = 1'b0; flush = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            idle();
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit s, w, f;
        logic [2:0]  o;
        logic [31:0] a, b;

        reset = 1'b0; start = 1'b0; wr_hl = 1'b0; flush = 1'b0;
        op = 3'd0; A = 32'd0; B = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cmp_en = 1'b1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        cyc(1, 0, 0, 3'd0, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        chk("mult_busy_len", n, 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        cyc(1, 0, 0, 3'd1, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        chk("multu_busy_len", n, 32'd5);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        cyc(1, 0, 0, 3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        chk("div_busy_len", n, 32'd10);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lo", lo, 32'hFFFF_FFFD);

        cyc(0, 1, 0, 3'd4, 32'h11, 32'd0);
        cyc(0, 1, 0, 3'd5, 32'h22, 32'd0);
        cyc(1, 0, 0, 3'd3, 32'd7, 32'd0);
        wait_idle(n);
        chk("divu0_busy_len", n, 32'd10);
        chk("divu0_hi", hi, 32'h11);
        chk("divu0_lo", lo, 32'h22);

        cyc(0, 1, 0, 3'd4, 32'hDEAD_BEEF, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'hDEAD_BEEF);
        cyc(0, 1, 0, 3'd5, 32'hCAFE_F00D, 32'd0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_lo", lo, 32'hCAFE_F00D);

        cyc(1, 0, 1, 3'd0, 32'd3, 32'd4);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        idle();
        chk("flush_hi", hi, 32'hDEAD_BEEF);
        chk("flush_lo", lo, 32'hCAFE_F00D);
        cyc(1, 0, 0, 3'd0, 32'd3, 32'd4);
        cyc(0, 0, 1, 3'd0, 32'd0, 32'd0);
        cyc(0, 0, 1, 3'd0, 32'd0, 32'd0);
        wait_idle(n);
        chk("flush_run_hi", hi, 32'd0);
        chk("flush_run_lo", lo, 32'd12);

        cyc(1, 0, 0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("divovf_hi", hi, 32'd0);
        chk("divovf_lo", lo, 32'h8000_0000);

        cyc(1, 0, 0, 3'd2, 32'd100, 32'd7);
        repeat (3) idle();
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (14) idle();
        chk("midrst_nocommit_hi", hi, 32'd0);
        chk("midrst_nocommit_lo", lo, 32'd0);

        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 4) == 0);
            w = !s && ($urandom_range(0, 5) == 0);
            f = ($urandom_range(0, 5) == 0);
            o = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 19) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            cyc(s, w, f, o, a, b);
        end
        wait_idle(n);
        idle();

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
